// File: rtl/pipe_stage_ctrl.sv
// Generic pipeline register bank: payload, valid bit and halt tag per stage,
// with priority stall/flush resolution, sticky halt and saturating counters.
module pipe_stage_ctrl #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned W      = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    input  logic                  in_hlt,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     stall_req,
    input  logic [STAGES-1:0]     flush_req,
    output logic [STAGES*W-1:0]   stage_data,
    output logic [STAGES-1:0]     stage_valid,
    output logic                  hlt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] tag_q;
    logic [W-1:0]      data_q [STAGES];
    logic              hlt_q;

    logic [STAGES-1:0] stall_v, flush_v;
    logic              hold_any, flush_any;
    int unsigned       h_idx, f_idx;
    logic              halt_now, hold_apply, flush_apply;

    logic [STAGES-1:0] prev_v, prev_t;
    logic [W-1:0]      prev_d [STAGES];
    logic [STAGES-1:0] nxt_v, nxt_t;
    logic [W-1:0]      nxt_d [STAGES];

    assign stall_v = stall_req & valid_q;
    assign flush_v = flush_req & valid_q;

    always_comb begin
        hold_any  = 1'b0;
        flush_any = 1'b0;
        h_idx     = 0;
        f_idx     = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (stall_v[i]) begin
                hold_any = 1'b1;
                h_idx    = i;
            end
            if (flush_v[i]) begin
                flush_any = 1'b1;
                f_idx     = i;
            end
        end
    end

    // A halt-tagged payload in the oldest stage freezes the pipe on the same
    // edge that raises hlt, so the payload stays visible and nothing retires.
    assign halt_now    = hlt_q | (valid_q[STAGES-1] & tag_q[STAGES-1]);
    assign flush_apply = !halt_now && flush_any && (!hold_any || f_idx >= h_idx);
    assign hold_apply  = !halt_now && hold_any && !flush_apply;
    assign in_ready    = !halt_now && !hold_apply && !flush_apply;

    always_comb begin
        prev_v    = {valid_q[STAGES-2:0], in_valid};
        prev_t    = {tag_q[STAGES-2:0], in_valid & in_hlt};
        prev_d[0] = in_data;
        for (int unsigned i = 1; i < STAGES; i++) begin
            prev_d[i] = data_q[i-1];
        end
    end

    always_comb begin
        nxt_v = valid_q;
        nxt_t = tag_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            nxt_d[i] = data_q[i];
        end
        if (!halt_now) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if ((flush_apply && i <= f_idx) || (hold_apply && i == h_idx + 1)) begin
                    nxt_v[i] = 1'b0;
                    nxt_t[i] = 1'b0;
                    nxt_d[i] = '0;
                end else if (!(hold_apply && i <= h_idx)) begin
                    nxt_v[i] = prev_v[i];
                    nxt_t[i] = prev_t[i];
                    nxt_d[i] = prev_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            tag_q     <= '0;
            hlt_q     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= nxt_v;
            tag_q   <= nxt_t;
            hlt_q   <= halt_now;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= nxt_d[i];
            end
            if (hold_apply && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_apply && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_data[i*W +: W] = data_q[i];
        end
    end

    assign stage_valid = valid_q;
    assign hlt         = hlt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: directed cycles push hand-computed
// expected state; a negedge monitor pops and compares.
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_hlt, in_ready;
    logic [15:0] in_data;
    logic [3:0]  stall_req, flush_req, stage_valid;
    logic [63:0] stage_data;
    logic        hlt;
    logic [15:0] stall_cnt, flush_cnt;

    logic        sat_valid, sat_ready, sat_hlt;
    logic [3:0]  sat_stall, sat_stage_valid;
    logic [63:0] sat_stage_data;
    logic [2:0]  sat_stall_cnt, sat_flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(.STAGES(4), .W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_hlt(in_hlt),
        .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
        .stage_data(stage_data), .stage_valid(stage_valid), .hlt(hlt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_ctrl #(.STAGES(4), .W(16), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(sat_valid), .in_data(16'h00AA), .in_hlt(1'b0),
        .in_ready(sat_ready), .stall_req(sat_stall), .flush_req(4'b0000),
        .stage_data(sat_stage_data), .stage_valid(sat_stage_valid), .hlt(sat_hlt),
        .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );

    typedef struct {
        string       name;
        logic [6:0]  mask;   // valid, data, hlt, scnt, fcnt, rdy, sat
        logic [3:0]  valid;
        logic [63:0] data;
        logic        hlt;
        logic [15:0] scnt, fcnt;
        logic        rdy;
        logic [2:0]  sat;
    } exp_t;

    localparam logic [6:0] M_ALL   = 7'h7F;
    localparam logic [6:0] M_NORDY = 7'h5F;
    localparam logic [6:0] M_SAT   = 7'h40;

    exp_t        sb[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nerr = 0;

    logic [6:0]  cur_mask = M_ALL;
    logic        exp_hlt = 1'b0;
    logic [15:0] exp_s = '0, exp_f = '0;
    logic [2:0]  exp_sat = '0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.mask[0]) chk({mon_e.name, "_valid"}, 64'(stage_valid), 64'(mon_e.valid));
            if (mon_e.mask[1])
                for (int i = 0; i < 4; i++)
                    if (mon_e.valid[i])
                        chk($sformatf("%s_s%0d", mon_e.name, i),
                            64'(stage_data[i*16 +: 16]), 64'(mon_e.data[i*16 +: 16]));
            if (mon_e.mask[2]) chk({mon_e.name, "_hlt"}, 64'(hlt), 64'(mon_e.hlt));
            if (mon_e.mask[3]) chk({mon_e.name, "_stall_cnt"}, 64'(stall_cnt), 64'(mon_e.scnt));
            if (mon_e.mask[4]) chk({mon_e.name, "_flush_cnt"}, 64'(flush_cnt), 64'(mon_e.fcnt));
            if (mon_e.mask[5]) chk({mon_e.name, "_in_ready"}, 64'(in_ready), 64'(mon_e.rdy));
            if (mon_e.mask[6]) chk({mon_e.name, "_sat_cnt"}, 64'(sat_stall_cnt), 64'(mon_e.sat));
        end
    end

    // Drive one cycle of inputs and queue the state expected before the next edge.
    task automatic cyc(input string nm, input logic iv, input logic [15:0] id, input logic ih,
                       input logic [3:0] st, input logic [3:0] fl,
                       input logic [3:0] ev, input logic [63:0] ed, input logic er);
        exp_t e;
        in_valid  = iv;
        in_data   = id;
        in_hlt    = ih;
        stall_req = st;
        flush_req = fl;
        e.name = nm; e.mask = cur_mask; e.valid = ev; e.data = ed; e.hlt = exp_hlt;
        e.scnt = exp_s; e.fcnt = exp_f; e.rdy = er; e.sat = exp_sat;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_data = '0; in_hlt = 0; stall_req = '0; flush_req = '0;
        sat_valid = 0; sat_stall = '0;
        @(posedge clk); #1;
        cyc("reset", 1, 16'h0000, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);
        rst = 1'b0;

        // back-to-back fill
        cyc("fill1", 1, 16'h0001, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);
        cyc("fill2", 1, 16'h0002, 0, 4'h0, 4'h0, 4'b0001, 64'h0000_0000_0000_0001, 1);
        cyc("fill3", 1, 16'h0003, 0, 4'h0, 4'h0, 4'b0011, 64'h0000_0000_0001_0002, 1);
        cyc("fill4", 1, 16'h0004, 0, 4'h0, 4'h0, 4'b0111, 64'h0000_0001_0002_0003, 1);
        cyc("fill5", 1, 16'h0005, 0, 4'h0, 4'h0, 4'b1111, 64'h0001_0002_0003_0004, 1);
        cyc("fill6", 1, 16'h0006, 0, 4'h0, 4'h0, 4'b1111, 64'h0002_0003_0004_0005, 1);

        // stall on stage 1 for two cycles
        cyc("stall_a", 1, 16'h0007, 0, 4'b0010, 4'h0, 4'b1111, 64'h0003_0004_0005_0006, 0);
        exp_s = 1;
        cyc("stall_b", 1, 16'h0007, 0, 4'b0010, 4'h0, 4'b1011, 64'h0004_0000_0005_0006, 0);
        exp_s = 2;
        cyc("stall_c", 1, 16'h0007, 0, 4'h0, 4'h0, 4'b0011, 64'h0000_0000_0005_0006, 1);
        cyc("stall_d", 1, 16'h0008, 0, 4'h0, 4'h0, 4'b0111, 64'h0000_0005_0006_0007, 1);

        // flush from stage 2
        cyc("flush_a", 1, 16'h0009, 0, 4'h0, 4'b0100, 4'b1111, 64'h0005_0006_0007_0008, 0);
        exp_f = 1;
        cyc("flush_b", 1, 16'h0009, 0, 4'h0, 4'h0, 4'b1000, 64'h0006_0000_0000_0000, 1);
        cyc("refill1", 1, 16'h000A, 0, 4'h0, 4'h0, 4'b0001, 64'h0000_0000_0000_0009, 1);
        cyc("refill2", 1, 16'h000B, 0, 4'h0, 4'h0, 4'b0011, 64'h0000_0000_0009_000A, 1);
        cyc("refill3", 1, 16'h000C, 0, 4'h0, 4'h0, 4'b0111, 64'h0000_0009_000A_000B, 1);

        // hold h=2 beats flush f=1, then flush alone
        cyc("hvf_a", 1, 16'h000D, 0, 4'b0100, 4'b0010, 4'b1111, 64'h0009_000A_000B_000C, 0);
        exp_s = 3;
        cyc("hvf_b", 1, 16'h000D, 0, 4'h0, 4'b0010, 4'b0111, 64'h0000_000A_000B_000C, 0);
        exp_f = 2;
        // same-stage stall and flush: flush wins
        cyc("heqf", 1, 16'h000D, 0, 4'b0100, 4'b0100, 4'b1100, 64'h000A_000B_0000_0000, 0);
        exp_f = 3;
        cyc("heqf_b", 0, 16'h0000, 0, 4'h0, 4'h0, 4'b1000, 64'h000B_0000_0000_0000, 1);
        // requests on bubbles are ignored
        cyc("bubble_req", 1, 16'h0011, 0, 4'b0011, 4'b0110, 4'b0000, 64'h0, 1);
        // flush[0] only blocks input
        cyc("flush0", 1, 16'h0012, 0, 4'h0, 4'b0001, 4'b0001, 64'h0000_0000_0000_0011, 0);
        exp_f = 4;
        cyc("flush0_b", 0, 16'h0000, 0, 4'h0, 4'h0, 4'b0010, 64'h0000_0000_0011_0000, 1);

        // halt-tagged payload walks to stage 3
        cyc("halt_in", 1, 16'h0BAD, 1, 4'h0, 4'h0, 4'b0100, 64'h0000_0011_0000_0000, 1);
        cyc("halt_1", 1, 16'h0021, 0, 4'h0, 4'h0, 4'b1001, 64'h0011_0000_0000_0BAD, 1);
        cyc("halt_2", 1, 16'h0022, 0, 4'h0, 4'h0, 4'b0011, 64'h0000_0000_0BAD_0021, 1);
        cyc("halt_3", 1, 16'h0023, 0, 4'h0, 4'h0, 4'b0111, 64'h0000_0BAD_0021_0022, 1);
        cur_mask = M_NORDY;
        cyc("halt_4", 1, 16'h0024, 0, 4'h0, 4'h0, 4'b1111, 64'h0BAD_0021_0022_0023, 1);
        cur_mask = M_ALL;
        exp_hlt  = 1'b1;
        for (int k = 0; k < 10; k++)
            cyc($sformatf("frozen%0d", k), 1, 16'h0025, 0, 4'b0010, 4'b0100,
                4'b1111, 64'h0BAD_0021_0022_0023, 0);

        // async reset in the middle of the freeze
        rst = 1'b1;
        exp_hlt = 1'b0; exp_s = 0; exp_f = 0;
        cyc("rst_mid", 1, 16'h0030, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);
        rst = 1'b0;
        cyc("post_rst", 1, 16'h0031, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);
        cyc("first_in", 0, 16'h0000, 0, 4'h0, 4'h0, 4'b0001, 64'h0000_0000_0000_0031, 1);

        // 3-bit counter saturation
        cur_mask  = M_SAT;
        sat_valid = 1'b1;
        cyc("sat0", 0, 16'h0000, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);
        sat_stall = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            exp_sat = (k - 1 > 7) ? 3'd7 : 3'(k - 1);
            cyc($sformatf("sat%0d", k), 0, 16'h0000, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);
        end
        sat_stall = '0;
        exp_sat   = 3'd7;
        cyc("sat_end", 0, 16'h0000, 0, 4'h0, 4'h0, 4'b0000, 64'h0, 1);

        repeat (2) @(negedge clk);
        #1;
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
